// File: rtl/axi_lite_sram_slave_if.sv
// AXI-lite bus bundle used between a master and the SRAM responder.
// Directions in each modport are as seen by the block that uses it.
interface axi_lite_if;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rresp;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        wready;
    logic        bvalid;
    logic        bresp;
    logic        bready;

    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );

    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder backed by a word-addressed SRAM, with independent read and
// write state machines, programmable response latency and out-of-window errors.
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          RD_LATENCY  = 1,
    parameter int          WR_LATENCY  = 1
) (
    input  logic       clk,
    input  logic       reset,
    axi_lite_if.slave  bus
);
    localparam int          IDX_W  = $clog2(DEPTH_WORDS);
    localparam int          RCW    = $clog2(RD_LATENCY + 1);
    localparam int          WCW    = $clog2(WR_LATENCY + 1);
    localparam logic [32:0] WINDOW = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read channel ----------------
    r_state_t       r_state_reg, r_state_next;
    logic [RCW-1:0] r_cnt_reg;
    logic [31:0]    ar_addr_reg;
    logic           arready_reg, rvalid_reg, rresp_reg;
    logic [31:0]    rdata_reg;
    logic           ar_hs, rd_hit;
    logic [31:0]    rd_addr, rd_offset;
    logic [IDX_W-1:0] rd_idx;

    assign ar_hs     = bus.arvalid && arready_reg;
    // With RD_LATENCY=1 the sample happens on the handshake edge itself.
    assign rd_addr   = (r_state_reg == R_IDLE) ? bus.araddr : ar_addr_reg;
    assign rd_offset = rd_addr - BASE_ADDR;
    assign rd_hit    = (rd_addr >= BASE_ADDR) && ({1'b0, rd_offset} < WINDOW);
    assign rd_idx    = rd_offset[IDX_W+1:2];

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE: if (ar_hs) r_state_next = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
            R_WAIT: if (r_cnt_reg == RCW'(1)) r_state_next = R_RESP;
            R_RESP: if (rvalid_reg && bus.rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_reg <= R_IDLE;
            r_cnt_reg   <= '0;
            ar_addr_reg <= '0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            arready_reg <= (r_state_next == R_IDLE);
            rvalid_reg  <= (r_state_next == R_RESP);
            if (ar_hs) begin
                ar_addr_reg <= bus.araddr;
                r_cnt_reg   <= RCW'(RD_LATENCY - 1);
            end else if (r_state_reg == R_WAIT) begin
                r_cnt_reg <= r_cnt_reg - RCW'(1);
            end
            if (r_state_next == R_RESP && r_state_reg != R_RESP) begin
                rdata_reg <= rd_hit ? mem[rd_idx] : '0;
                rresp_reg <= !rd_hit;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t       w_state_reg, w_state_next;
    logic [WCW-1:0] w_cnt_reg;
    logic [31:0]    aw_addr_reg, w_data_reg;
    logic [3:0]     w_mask_reg;
    logic           aw_done_reg, w_done_reg, aw_done_next, w_done_next;
    logic           awready_reg, wready_reg, bvalid_reg, bresp_reg;
    logic           aw_hs, w_hs, wr_hit, wr_commit;
    logic [31:0]    wr_addr, wr_offset, wr_data;
    logic [3:0]     wr_mask;
    logic [IDX_W-1:0] wr_idx;
    logic           unused_wmask_hi;

    assign unused_wmask_hi = ^bus.wmask[7:4];
    assign aw_hs     = bus.awvalid && awready_reg;
    assign w_hs      = bus.wvalid && wready_reg;
    // Captured beats come from the holding registers, fresh ones straight from the bus.
    assign wr_addr   = aw_done_reg ? aw_addr_reg : bus.awaddr;
    assign wr_data   = w_done_reg  ? w_data_reg  : bus.wdata;
    assign wr_mask   = w_done_reg  ? w_mask_reg  : bus.wmask[3:0];
    assign wr_offset = wr_addr - BASE_ADDR;
    assign wr_hit    = (wr_addr >= BASE_ADDR) && ({1'b0, wr_offset} < WINDOW);
    assign wr_idx    = wr_offset[IDX_W+1:2];
    assign wr_commit = reset && (w_state_next == W_RESP) && (w_state_reg != W_RESP);

    always_comb begin
        w_state_next = w_state_reg;
        aw_done_next = aw_done_reg || aw_hs;
        w_done_next  = w_done_reg || w_hs;
        case (w_state_reg)
            W_IDLE: if (aw_done_next && w_done_next)
                        w_state_next = (WR_LATENCY == 1) ? W_RESP : W_WAIT;
            W_WAIT: if (w_cnt_reg == WCW'(1)) w_state_next = W_RESP;
            W_RESP: if (bvalid_reg && bus.bready) begin
                        w_state_next = W_IDLE;
                        aw_done_next = 1'b0;
                        w_done_next  = 1'b0;
                    end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_reg <= W_IDLE;
            w_cnt_reg   <= '0;
            aw_addr_reg <= '0;
            w_data_reg  <= '0;
            w_mask_reg  <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            awready_reg <= (w_state_next == W_IDLE) && !aw_done_next;
            wready_reg  <= (w_state_next == W_IDLE) && !w_done_next;
            bvalid_reg  <= (w_state_next == W_RESP);
            if (aw_hs) aw_addr_reg <= bus.awaddr;
            if (w_hs) begin
                w_data_reg <= bus.wdata;
                w_mask_reg <= bus.wmask[3:0];
            end
            if (w_state_reg == W_IDLE && w_state_next != W_IDLE)
                w_cnt_reg <= WCW'(WR_LATENCY - 1);
            else if (w_state_reg == W_WAIT)
                w_cnt_reg <= w_cnt_reg - WCW'(1);
            if (wr_commit) bresp_reg <= !wr_hit;
        end
    end

    // Memory is deliberately not reset; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_commit && wr_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign bus.arready = arready_reg;
    assign bus.rvalid  = rvalid_reg;
    assign bus.rdata   = rdata_reg;
    assign bus.rresp   = rresp_reg;
    assign bus.awready = awready_reg;
    assign bus.wready  = wready_reg;
    assign bus.bvalid  = bvalid_reg;
    assign bus.bresp   = bresp_reg;
endmodule
